spi_slave: RTL and testbench
============================

# spi_slave

SPI responder (peripheral end) for the same SPI bus the team's `spi_master` drives. It oversamples `sclk`, `cs_n` and `mosi` in the system clock domain and shifts in full-duplex, MSB first, for all four CPOL/CPHA modes. Received words leave on an AXI-Stream source. Transmit words arrive on an AXI-Stream sink and are driven onto `miso`. It sits between the board SPI pins and fabric logic, for example as the far end of a loopback bench against `spi_master`.

## Interface
- `TRANSFER_WIDTH`, 8: bits per SPI word and AXIS `tdata` width (≥2).
- `CPOL`, 0: idle level of `sclk`.
- `CPHA`, 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
- `IDLE_WORD`, all ones: word transmitted when no transmit data is available.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `sclk`, `cs_n`, `mosi` in 1 each: asynchronous SPI pins, each passed through a 2-FF synchronizer.
- `miso` out 1: serial data out.
- `miso_oe` out 1: tri-state enable, high while the frame is ACTIVE.
- `mosi_stream` axis_interface.Source (`DATA_WIDTH=TRANSFER_WIDTH`, `KEEP_WIDTH=1`): received words; `tlast`=1, `tkeep`=1, `tid`/`tdest`/`tuser`=0.
- `miso_stream` axis_interface.Sink: words to transmit; `tlast` is ignored.
- `overrun` out 1: one-cycle pulse when a received word is dropped.
- `underrun` out 1: one-cycle pulse when `IDLE_WORD` is loaded.
- `abort` out 1: one-cycle pulse when `cs_n` rises with a partial word.

## Operation
- Edge detection runs on the synchronized `sclk` (previous vs current), giving a leading-edge and a trailing-edge strobe.
  - Leading edge is the transition away from CPOL.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other one.
- States:
  - WAIT_IDLE (entered from reset): go to IDLE when synchronized `cs_n`=1. A slave released from reset mid-frame never joins that frame.
  - IDLE: on synchronized `cs_n` falling, go to ACTIVE and set `bit_cnt`=0.
  - ACTIVE: on synchronized `cs_n`=1, return to IDLE. If `bit_cnt`≠0, pulse `abort` and discard the partial rx word.
- Receive: on each sample edge, `rx_shift <= {rx_shift[W-2:0], mosi_sync}` and `bit_cnt++`. When `bit_cnt`=W-1 on a sample edge:
  - the word is complete and `bit_cnt` wraps to 0;
  - if `mosi_stream.tvalid`=0, present `{rx_shift[W-2:0], mosi_sync}` with `tvalid`=1;
  - otherwise drop the new word, pulse `overrun`, and keep the held word unchanged.
  - `tvalid` clears on `tvalid && tready`.
- Transmit holding register (1 entry): `miso_stream.tready = !hold_valid`. Accepting a beat sets `hold_valid`.
- Load points:
  - CPHA=0: the cycle ACTIVE is entered, and each shift edge immediately following a word-completing sample edge.
  - CPHA=1: each shift edge while `bit_cnt`=0.
- At a load point:
  - if `hold_valid`=1: `tx_shift <= hold` and `hold_valid <= 0`;
  - else: `tx_shift <= IDLE_WORD` and pulse `underrun`.
  - A beat accepted in the same cycle goes into `hold`; it is not loaded in that cycle.
- Other shift edges: `tx_shift <= tx_shift << 1`.
- `miso = tx_shift[W-1]`. `miso_oe` = (state==ACTIVE).
- `cs_n` rising discards `tx_shift`. `hold` is kept across frames.

## Timing
- Reset values:
  - `miso`=0, `miso_oe`=0, `overrun`/`underrun`/`abort`=0.
  - `mosi_stream.tvalid`=0, `mosi_stream.tdata`=0.
  - `miso_stream.tready`=0 during reset, 1 in the first cycle after reset.
  - `hold_valid`=0, `bit_cnt`=0, state=WAIT_IDLE.
- Reset mid-frame discards all partial and held data.
- Pin-to-strobe latency: 3 `clk` cycles (2 synchronizer stages + edge register). `miso` changes 1 cycle after the strobe, i.e. 4 cycles after the pin edge.
- Requirements on the master:
  - `sclk` half period ≥ 6 `clk` cycles;
  - `cs_n` fall to first `sclk` edge ≥ 6 `clk` cycles;
  - last `sclk` edge to `cs_n` rise ≥ 4 `clk` cycles.
  - `spi_master` at CLKS_PER_HALF_BIT=50 on the same clock meets all three.
- Received word: `mosi_stream.tvalid` rises 1 cycle after the completing sample strobe.
- AXIS rules: `tdata` is stable while `tvalid`=1 and `tready`=0; `tvalid` never drops without a handshake.
- Simultaneous events:
  - word completion and downstream handshake in the same cycle: no overrun; the new word is taken.
  - `cs_n` rise and a sample strobe in the same cycle: `cs_n` wins and the bit is ignored.

## Test plan
- All four CPOL/CPHA modes, master sends 0xA5 while 0x3C is preloaded on `miso_stream` -> `mosi_stream` delivers 0xA5 once with `tlast`=1; master captures 0x3C; `underrun`/`overrun`/`abort` stay 0.
- Three back-to-back words (0x01, 0x02, 0x03) with `cs_n` held low and transmit words 0x10, 0x20, 0x30 fed as `tready` allows -> rx order 0x01, 0x02, 0x03; master receives 0x10, 0x20, 0x30.
- No transmit data supplied, master sends 0x55 -> master receives 0xFF; `underrun` pulses exactly once.
- `mosi_stream.tready` held 0, master sends 0x11 then 0x22 -> `tdata` holds 0x11; `overrun` pulses once; after `tready`=1 only 0x11 is delivered.
- `cs_n` rises after 5 bits -> no `mosi_stream` beat, `abort` pulses once; the next full frame 0x7E is received correctly.
- `reset` asserted after 4 bits with `cs_n` still low -> all outputs return to reset values; no activity until `cs_n` goes high; the following frame 0xC3 is received correctly.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI peripheral, full-duplex MSB first in all CPOL/CPHA modes,
// with an AXI-Stream source for received words and an AXI-Stream sink for transmit words.
module spi_slave #(
    parameter int                        TRANSFER_WIDTH = 8,
    parameter bit                        CPOL           = 1'b0,
    parameter bit                        CPHA           = 1'b0,
    parameter logic [TRANSFER_WIDTH-1:0] IDLE_WORD      = '1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sclk,
    input  logic                      cs_n,
    input  logic                      mosi,
    output logic                      miso,
    output logic                      miso_oe,
    output logic [TRANSFER_WIDTH-1:0] mosi_stream_tdata,
    output logic                      mosi_stream_tvalid,
    input  logic                      mosi_stream_tready,
    output logic                      mosi_stream_tlast,
    output logic                      mosi_stream_tkeep,
    output logic                      mosi_stream_tid,
    output logic                      mosi_stream_tdest,
    output logic                      mosi_stream_tuser,
    input  logic [TRANSFER_WIDTH-1:0] miso_stream_tdata,
    input  logic                      miso_stream_tvalid,
    output logic                      miso_stream_tready,
    input  logic                      miso_stream_tlast,
    output logic                      overrun,
    output logic                      underrun,
    output logic                      abort
);
    localparam int            CW   = $clog2(TRANSFER_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(TRANSFER_WIDTH - 1);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

    state_t                    state, state_n;
    logic [1:0]                sclk_s, cs_s, mosi_s;
    logic                      sclk_prev, lead, trail;
    logic [CW-1:0]             bit_cnt;
    logic [TRANSFER_WIDTH-1:0] rx_shift, tx_shift, hold;
    logic                      hold_valid;
    logic                      cs_sync, mosi_sync;
    logic                      enter, leave, act, do_sample, do_shift, done, load, take;
    logic                      tlast_unused;

    assign cs_sync            = cs_s[1];
    assign mosi_sync          = mosi_s[1];
    assign miso               = tx_shift[TRANSFER_WIDTH-1];
    assign miso_oe            = state == ACTIVE;
    assign miso_stream_tready = !hold_valid && !reset;
    assign mosi_stream_tlast  = 1'b1;
    assign mosi_stream_tkeep  = 1'b1;
    assign mosi_stream_tid    = 1'b0;
    assign mosi_stream_tdest  = 1'b0;
    assign mosi_stream_tuser  = 1'b0;
    assign tlast_unused       = miso_stream_tlast;

    // cs_n resets to "selected" so a slave released mid-frame waits for a real idle
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_s    <= {2{CPOL}};
            cs_s      <= 2'b00;
            mosi_s    <= 2'b00;
            sclk_prev <= CPOL;
            lead      <= 1'b0;
            trail     <= 1'b0;
        end else begin
            sclk_s    <= {sclk_s[0], sclk};
            cs_s      <= {cs_s[0], cs_n};
            mosi_s    <= {mosi_s[0], mosi};
            sclk_prev <= sclk_s[1];
            lead      <= sclk_s[1] != sclk_prev && sclk_prev == CPOL;
            trail     <= sclk_s[1] != sclk_prev && sclk_prev != CPOL;
        end
    end

    always_comb begin
        state_n   = cs_sync ? IDLE : (state == WAIT_IDLE ? WAIT_IDLE : ACTIVE);
        enter     = state == IDLE && !cs_sync;
        leave     = state == ACTIVE && cs_sync;
        act       = state == ACTIVE && !cs_sync;
        do_sample = act && (CPHA ? trail : lead);
        do_shift  = act && (CPHA ? lead : trail);
        done      = do_sample && bit_cnt == LAST;
        load      = (enter && !CPHA) || (do_shift && bit_cnt == '0);
        take      = miso_stream_tvalid && miso_stream_tready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= WAIT_IDLE;
            bit_cnt            <= '0;
            rx_shift           <= '0;
            tx_shift           <= '0;
            hold               <= '0;
            hold_valid         <= 1'b0;
            mosi_stream_tdata  <= '0;
            mosi_stream_tvalid <= 1'b0;
            overrun            <= 1'b0;
            underrun           <= 1'b0;
            abort              <= 1'b0;
        end else begin
            state      <= state_n;
            overrun    <= done && mosi_stream_tvalid && !mosi_stream_tready;
            underrun   <= load && !hold_valid;
            abort      <= leave && bit_cnt != '0;
            hold_valid <= take || (hold_valid && !load);
            if (take)
                hold <= miso_stream_tdata;
            if (enter || leave)
                bit_cnt <= '0;
            else if (do_sample)
                bit_cnt <= done ? '0 : bit_cnt + 1'b1;
            if (do_sample)
                rx_shift <= {rx_shift[TRANSFER_WIDTH-2:0], mosi_sync};
            // a word completing during a handshake replaces the departing one
            if (done && (!mosi_stream_tvalid || mosi_stream_tready)) begin
                mosi_stream_tvalid <= 1'b1;
                mosi_stream_tdata  <= {rx_shift[TRANSFER_WIDTH-2:0], mosi_sync};
            end else if (mosi_stream_tready) begin
                mosi_stream_tvalid <= 1'b0;
            end
            if (load)
                tx_shift <= hold_valid ? hold : IDLE_WORD;
            else if (do_shift)
                tx_shift <= tx_shift << 1;
            else if (leave)
                tx_shift <= '0;
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: one spi_slave per CPOL/CPHA mode driven by a behavioural SPI master,
// with a queue model for transmit loads and receive order.
module tb_spi_slave;
    localparam int H = 8;

    logic            clk = 1'b0;
    logic            reset, b, mosi, rdy, txv;
    logic [3:0]      cs_n, sclk_p, miso, oe, rxv, rxl, rxk, rxid, rxdst, rxu, txr, ov, un, ab;
    logic [3:0][7:0] rxd;
    logic [7:0]      txd;
    logic [7:0]      txq[$], txm[$], rxq[$];
    int              m, total, bad, uc, oc, ac;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign sclk_p[g] = b ^ (g >= 2);
        spi_slave #(.TRANSFER_WIDTH(8), .CPOL(g >= 2), .CPHA(g % 2 == 1)) dut (
            .clk(clk), .reset(reset), .sclk(sclk_p[g]), .cs_n(cs_n[g]), .mosi(mosi),
            .miso(miso[g]), .miso_oe(oe[g]),
            .mosi_stream_tdata(rxd[g]), .mosi_stream_tvalid(rxv[g]), .mosi_stream_tready(rdy),
            .mosi_stream_tlast(rxl[g]), .mosi_stream_tkeep(rxk[g]), .mosi_stream_tid(rxid[g]),
            .mosi_stream_tdest(rxdst[g]), .mosi_stream_tuser(rxu[g]),
            .miso_stream_tdata(txd), .miso_stream_tvalid(txv && m == g),
            .miso_stream_tready(txr[g]), .miso_stream_tlast(1'b1),
            .overrun(ov[g]), .underrun(un[g]), .abort(ab[g]));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_c(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rdy(input logic v);
        @(posedge clk);
        #1 rdy = v;
    endtask

    task automatic push(input logic [7:0] w);
        txq.push_back(w);
        txm.push_back(w);
    endtask

    task automatic clr();
        uc = 0;
        oc = 0;
        ac = 0;
        rxq.delete();
    endtask

    // every load takes the next queued word or sends 0xFF; CPHA=0 also loads on entry
    function automatic void tx_model(input int nb, input int cpha, output logic [23:0] ecap, output int eu);
        int nl = cpha != 0 ? (nb + 7) / 8 : nb / 8 + 1;
        ecap = '0;
        eu = 0;
        for (int k = 0; k < nl; k++) begin
            logic [7:0] w;
            if (txm.size() > 0) w = txm.pop_front();
            else begin
                w = 8'hFF;
                eu++;
            end
            if (k < nb / 8) ecap = {ecap[15:0], w};
        end
    endfunction

    task automatic xfer(input int nb, input logic [23:0] d, input bit keep_cs, output logic [23:0] cap);
        cap = '0;
        wait_c(4);
        cs_n = ~(4'b1 << m);
        for (int i = nb - 1; i >= 0; i--) begin
            if (m % 2 == 0) begin
                mosi = d[i];
                wait_c(H);
                b = 1'b1;
                cap = {cap[22:0], miso[m]};
                wait_c(H);
                b = 1'b0;
            end else begin
                wait_c(H);
                b = 1'b1;
                mosi = d[i];
                wait_c(H);
                b = 1'b0;
                cap = {cap[22:0], miso[m]};
            end
            if (i == nb - 1) chk("miso_oe_active", oe[m], 1'b1);
        end
        wait_c(H);
        if (!keep_cs) begin
            cs_n = 4'hF;
            wait_c(H);
            chk("miso_oe_idle", oe[m], 1'b0);
        end
    endtask

    task automatic frame(input string tag, input int nb, input logic [23:0] d);
        logic [23:0] cap, ecap;
        int eu;
        clr();
        tx_model(nb, m % 2, ecap, eu);
        xfer(nb, d, 1'b0, cap);
        wait_c(20);
        if (nb % 8 == 0) chk({tag, "_miso"}, cap, ecap);
        chk({tag, "_underrun"}, uc, eu);
        chk({tag, "_overrun"}, oc, 0);
        chk({tag, "_abort"}, ac, nb % 8 != 0);
        chk({tag, "_rxcount"}, rxq.size(), nb / 8);
        for (int k = 0; k < rxq.size() && k < nb / 8; k++)
            chk({tag, "_rxdata"}, rxq[k], (d >> (8 * (nb / 8 - 1 - k))) & 24'hFF);
    endtask

    initial begin
        logic rl;
        rl = 1'b0;
        txv = 1'b0;
        txd = '0;
        forever begin
            @(negedge clk);
            if (txv && rl) begin
                txq.delete(0);
                txv = 1'b0;
            end
            if (!txv && txq.size() > 0) begin
                txd = txq[0];
                txv = 1'b1;
            end
            rl = txr[m];
        end
    end

    initial forever begin
        @(negedge clk);
        if (ov[m]) oc++;
        if (un[m]) uc++;
        if (ab[m]) ac++;
        if (rxv[m] && rdy) begin
            rxq.push_back(rxd[m]);
            chk("rx_sideband", {rxl[m], rxk[m], rxid[m], rxdst[m], rxu[m]}, 5'b11000);
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        logic [23:0] cap, ecap;
        int eu;
        b = 1'b0;
        mosi = 1'b0;
        cs_n = 4'hF;
        reset = 1'b1;
        rdy = 1'b1;
        m = 0;
        total = 0;
        bad = 0;
        clr();
        wait_c(3);
        chk("rst_miso", miso, 4'h0);
        chk("rst_miso_oe", oe, 4'h0);
        chk("rst_tvalid", rxv, 4'h0);
        chk("rst_tdata", rxd, 32'h0);
        chk("rst_pulses", {ov, un, ab}, 12'h0);
        chk("rst_tready", txr, 4'h0);
        reset = 1'b0;
        wait_c(1);
        chk("post_rst_tready", txr, 4'hF);
        wait_c(10);
        for (int i = 0; i < 4; i++) begin
            m = i;
            push(8'h3C);
            if (i % 2 == 0) push(8'($urandom));
            frame("mode", 8, 24'hA5);
        end
        m = 0;
        push(8'h10);
        push(8'h20);
        push(8'h30);
        push(8'h40);
        frame("b2b", 24, 24'h010203);
        m = 1;
        frame("underrun", 8, 24'h55);
        m = 0;
        repeat (3) push(8'($urandom));
        set_rdy(1'b0);
        clr();
        tx_model(16, 0, ecap, eu);
        xfer(16, 24'h1122, 1'b0, cap);
        wait_c(20);
        chk("ovr_miso", cap, ecap);
        chk("ovr_tvalid", rxv[m], 1'b1);
        chk("ovr_tdata", rxd[m], 8'h11);
        chk("ovr_pulse", oc, 1);
        chk("ovr_none_yet", rxq.size(), 0);
        set_rdy(1'b1);
        wait_c(5);
        chk("ovr_count", rxq.size(), 1);
        if (rxq.size() > 0) chk("ovr_data", rxq[0], 8'h11);
        chk("ovr_tvalid_clear", rxv[m], 1'b0);
        m = 2;
        push(8'($urandom));
        frame("abort", 5, 24'h16);
        push(8'h81);
        push(8'($urandom));
        frame("after_abort", 8, 24'h7E);
        m = 3;
        clr();
        xfer(4, 24'h9, 1'b1, cap);
        reset = 1'b1;
        wait_c(2);
        chk("mid_rst_miso", miso[m], 1'b0);
        chk("mid_rst_oe", oe[m], 1'b0);
        chk("mid_rst_tvalid", rxv[m], 1'b0);
        chk("mid_rst_tdata", rxd[m], 8'h00);
        chk("mid_rst_tready", txr[m], 1'b0);
        reset = 1'b0;
        wait_c(1);
        chk("mid_post_tready", txr[m], 1'b1);
        clr();
        repeat (4) begin
            wait_c(H);
            b = ~b;
        end
        wait_c(H);
        chk("wait_idle_oe", oe[m], 1'b0);
        chk("wait_idle_rx", rxq.size(), 0);
        chk("wait_idle_pulses", uc + oc + ac, 0);
        cs_n = 4'hF;
        wait_c(10);
        frame("after_reset", 8, 24'hC3);
        repeat (6) begin
            int nw, np, nl;
            m = $urandom_range(0, 3);
            nw = $urandom_range(1, 3);
            nl = m % 2 == 1 ? nw : nw + 1;
            np = $urandom_range(0, nl);
            for (int k = 0; k < np; k++) push(8'($urandom));
            frame("random", nw * 8, 24'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
